simple_dual_port_be_ram: RTL and testbench
==========================================

Name: simple_dual_port_be_ram

Overview:
Single-clock simple dual-port RAM with one write port and one read port. Adds the following over the 2-clock RAM:
- byte-lane write enables
- selectable read latency (1 or 2) with a read-valid strobe
- defined read-during-write collision behaviour
- optional hardware clear sweep after reset

Intended for CPU/PPU-side work RAMs and line buffers that need deterministic post-reset contents on hardware, not only in simulation.

Parameters:
DATA_WIDTH, 32, word width in bits; must be an integer multiple of BYTE_WIDTH.
BYTE_WIDTH, 8, lane width; NB = DATA_WIDTH/BYTE_WIDTH byte enables.
RAM_DEPTH, 256, number of words; AW = __clogb2__(RAM_DEPTH) address bits.
RAM_STYLE, "block", "block" or "distributed", passed to ram_style attribute.
RD_LATENCY, 1, 1 or 2 cycles from accepted rd_i to rd_valid_o/rd_data_o.
RDW_MODE, "READ_FIRST", "READ_FIRST" or "WRITE_FIRST", same-address same-cycle collision result.
CLEAR_ON_RESET, "TRUE", "TRUE" runs the clear sweep after reset; "FALSE" has no sweep.
CLEAR_VAL, 0, DATA_WIDTH-bit word written to every location by the sweep.

Ports:
clk_i  input  1  single clock, all logic on rising edge
rst_i  input  1  asynchronous, active-high reset
wr_i  input  1  write request
wr_addr_i  input  AW  write address
wr_be_i  input  NB  byte enables; lane k covers bits [k*BYTE_WIDTH +: BYTE_WIDTH]
wr_data_i  input  DATA_WIDTH  write data
rd_i  input  1  read request
rd_addr_i  input  AW  read address
rd_data_o  output  DATA_WIDTH  read data; holds last value between reads
rd_valid_o  output  1  one-cycle strobe, rd_data_o is new this cycle
busy_o  output  1  clear sweep in progress; accesses ignored

Behaviour:
- One clock domain. rst_i is asynchronous and active-high.
- Reset values:
  - rd_data_o = 0
  - rd_valid_o = 0
  - busy_o = 1 if CLEAR_ON_RESET="TRUE", otherwise 0
  - read pipeline valid bits = 0, so in-flight reads are flushed
  - clear counter = 0
  - RAM contents are not touched by rst_i itself.
- Write:
  - Accepted when wr_i=1, busy_o=0 and wr_addr_i < RAM_DEPTH.
  - Only lanes with wr_be_i[k]=1 are updated at the clock edge.
  - wr_be_i = 0 is a no-op.
  - An out-of-range address is silently dropped.
- Read:
  - Accepted when rd_i=1 and busy_o=0.
  - RD_LATENCY=1: RAM output register is loaded; rd_valid_o=1 on the next cycle.
  - RD_LATENCY=2: an additional output register is loaded from stage 1 only when the stage-1 valid is set; rd_valid_o is asserted 2 cycles after acceptance.
  - Back-to-back reads are fully pipelined: 1 result per cycle.
  - An out-of-range read returns all zeros with a normal rd_valid_o.
  - When no read is accepted, rd_data_o holds its value and rd_valid_o=0.
- Collision (accepted wr and rd, same address, same cycle):
  - READ_FIRST: returns the pre-write word.
  - WRITE_FIRST: returns the merged word. Enabled lanes come from wr_data_i; other lanes are the old contents.
  - A write in cycle N followed by a read in cycle N+1 always returns new data in both modes.
- Clear sweep (CLEAR_ON_RESET="TRUE"):
  - States: CLEAR, IDLE.
  - After rst_i deasserts, CLEAR writes CLEAR_VAL to address counter 0,1,...,RAM_DEPTH-1, one word per cycle.
  - After writing RAM_DEPTH-1, the block moves to IDLE and busy_o falls on the next edge.
  - Exactly RAM_DEPTH active clock edges from the first edge with rst_i low until busy_o=0.
  - During CLEAR, wr_i and rd_i are ignored; no rd_valid_o is produced.
  - rst_i asserted mid-sweep restarts the sweep from address 0.
- CLEAR_ON_RESET="FALSE": the FSM stays in IDLE and busy_o=0 permanently. Initial contents are unspecified; the simulation model may randomise them.
- Illegal parameter combinations (RD_LATENCY not 1/2, DATA_WIDTH % BYTE_WIDTH != 0) stop elaboration via a generate-time error.

Test Plan:
1. Configuration: DEPTH=16, CLEAR_VAL=32'hA5A5A5A5, CLEAR_ON_RESET="TRUE".
   - Release rst_i -> busy_o high exactly 16 cycles.
   - Then read all 16 addresses back-to-back -> 16 consecutive rd_valid_o pulses, each 32'hA5A5A5A5.
2. Byte enables:
   - Write 32'h11223344 with be=4'b1111 to addr 3.
   - Then write 32'hAABBCCDD with be=4'b0101 to addr 3.
   - Read addr 3 -> 32'h11BB33DD.
3. Collision:
   - Addr 5 holds 32'h0.
   - Same-cycle write 32'hDEADBEEF (be=4'b0011) plus read of addr 5.
   - READ_FIRST -> 32'h00000000; WRITE_FIRST -> 32'h0000BEEF.
   - A following read of addr 5 -> 32'h0000BEEF in both modes.
4. Latency:
   - RD_LATENCY=2, reads on cycles 0,1,2 to addrs 0,1,2 holding 10,20,30.
   - rd_valid_o high on cycles 2,3,4 with 10,20,30.
   - rd_data_o holds 30 afterwards with rd_valid_o=0.
5. Reset mid-sweep and mid-read:
   - Assert rst_i at sweep address 7 -> rd_data_o=0 and busy_o=1 immediately, asynchronously.
   - After release, the sweep restarts at address 0 and takes the full RAM_DEPTH cycles.
   - An in-flight read at reset produces no rd_valid_o.
6. Access during busy and range check:
   - Write/read requests during the sweep -> ignored; memory equals CLEAR_VAL afterwards.
   - With DEPTH=12, write to addr 13 is dropped.
   - Read of addr 13 -> 0 with rd_valid_o.

Source files
------------

// File: rtl/simple_dual_port_be_ram.sv
// rtl/simple_dual_port_be_ram.sv - single-clock simple dual-port RAM with byte enables and clear sweep
//
// Purpose:
//    One write port, one read port, one clock. Byte-lane write enables,
//    read latency of 1 or 2 cycles with a read-valid strobe, defined
//    same-address read-during-write result, and an optional sweep that
//    writes CLEAR_VAL to every word after reset.
//
// Ports:
//    clk_i       single clock, rising edge
//    rst_i       asynchronous active-high reset (RAM contents untouched)
//    wr_i        write request
//    wr_addr_i   write address (out-of-range writes are dropped)
//    wr_be_i     byte enables, lane k = bits [k*BYTE_WIDTH +: BYTE_WIDTH]
//    wr_data_i   write data
//    rd_i        read request
//    rd_addr_i   read address (out-of-range reads return zero)
//    rd_data_o   read data, holds its value between reads
//    rd_valid_o  one-cycle strobe, rd_data_o is new this cycle
//    busy_o      clear sweep in progress, accesses are ignored

module simple_dual_port_be_ram #(
   parameter int                    DATA_WIDTH     = 32,
   parameter int                    BYTE_WIDTH     = 8,
   parameter int                    RAM_DEPTH      = 256,
   parameter string                 RAM_STYLE      = "block",
   parameter int                    RD_LATENCY     = 1,
   parameter string                 RDW_MODE       = "READ_FIRST",
   parameter string                 CLEAR_ON_RESET = "TRUE",
   parameter logic [DATA_WIDTH-1:0] CLEAR_VAL      = '0,
   localparam int                   NB             = DATA_WIDTH / BYTE_WIDTH,
   localparam int                   AW             = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  wr_i,
   input  logic [AW-1:0]         wr_addr_i,
   input  logic [NB-1:0]         wr_be_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_i,
   input  logic [AW-1:0]         rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o,
   output logic                  rd_valid_o,
   output logic                  busy_o
);

   generate
      if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
         $error("simple_dual_port_be_ram: RD_LATENCY must be 1 or 2");
      end
      if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_bad_width
         $error("simple_dual_port_be_ram: DATA_WIDTH must be a multiple of BYTE_WIDTH");
      end
   endgenerate

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_t;

   localparam bit            CLEAR_EN    = (CLEAR_ON_RESET == "TRUE");
   localparam bit            WRITE_FIRST = (RDW_MODE == "WRITE_FIRST");
   localparam logic [AW-1:0] LAST_ADDR   = AW'(RAM_DEPTH - 1);
   localparam logic [AW:0]   DEPTH_LIM   = (AW + 1)'(RAM_DEPTH);
   localparam state_t        RESET_STATE = CLEAR_EN ? ST_CLEAR : ST_IDLE;

   (* ram_style = RAM_STYLE *) logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

   state_t                state;
   logic                  busy;
   logic [AW-1:0]         clr_addr;

   logic                  wr_in_range;
   logic                  rd_in_range;
   logic                  wr_accept;
   logic                  rd_accept;

   logic                  mem_we;
   logic [AW-1:0]         mem_waddr;
   logic [NB-1:0]         mem_be;
   logic [DATA_WIDTH-1:0] mem_wdata;

   logic [DATA_WIDTH-1:0] rd_old;
   logic [DATA_WIDTH-1:0] rd_word;

   logic                  s1_valid;
   logic [DATA_WIDTH-1:0] s1_data;

   assign wr_in_range = ({1'b0, wr_addr_i} < DEPTH_LIM);
   assign rd_in_range = ({1'b0, rd_addr_i} < DEPTH_LIM);
   assign wr_accept   = wr_i && !busy && wr_in_range;
   assign rd_accept   = rd_i && !busy;
   assign busy_o      = busy;

   // Clear sweep: busy falls on the same edge that writes the last word,
   // so busy_o is high for exactly RAM_DEPTH edges after reset release.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state    <= RESET_STATE;
         busy     <= CLEAR_EN;
         clr_addr <= '0;
      end else if (state == ST_CLEAR) begin
         if (clr_addr == LAST_ADDR) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
         end else begin
            clr_addr <= clr_addr + AW'(1);
         end
      end
   end

   // Single physical write port shared by the sweep and user writes.
   // The sweep is held off while rst_i is high so reset alone never
   // modifies the array.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = wr_addr_i;
      mem_be    = wr_be_i;
      mem_wdata = wr_data_i;
      if (state == ST_CLEAR) begin
         mem_we    = !rst_i;
         mem_waddr = clr_addr;
         mem_be    = '1;
         mem_wdata = CLEAR_VAL;
      end else if (wr_accept) begin
         mem_we = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         for (int k = 0; k < NB; k++) begin
            if (mem_be[k]) begin
               mem[mem_waddr][k*BYTE_WIDTH +: BYTE_WIDTH] <= mem_wdata[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
   end

   // The array read happens before the write lands, which gives the
   // READ_FIRST result for free; WRITE_FIRST overlays the enabled lanes.
   always_comb begin
      rd_old  = mem[rd_addr_i];
      rd_word = rd_old;
      if (WRITE_FIRST && wr_accept && (wr_addr_i == rd_addr_i)) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_be_i[k]) begin
               rd_word[k*BYTE_WIDTH +: BYTE_WIDTH] = wr_data_i[k*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
      if (!rd_in_range) begin
         rd_word = '0;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
      end else begin
         s1_valid <= rd_accept;
         if (rd_accept) begin
            s1_data <= rd_word;
         end
      end
   end

   generate
      if (RD_LATENCY == 2) begin : g_lat2
         logic                  s2_valid;
         logic [DATA_WIDTH-1:0] s2_data;

         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               s2_valid <= 1'b0;
               s2_data  <= '0;
            end else begin
               s2_valid <= s1_valid;
               if (s1_valid) begin
                  s2_data <= s1_data;
               end
            end
         end

         assign rd_valid_o = s2_valid;
         assign rd_data_o  = s2_data;
      end else begin : g_lat1
         assign rd_valid_o = s1_valid;
         assign rd_data_o  = s1_data;
      end
   endgenerate

endmodule

// File: tb/tb_simple_dual_port_be_ram.sv
// tb/tb_simple_dual_port_be_ram.sv - self-checking bench for simple_dual_port_be_ram
//
// Four instances share one stimulus stream:
//    0: depth 16, latency 1, READ_FIRST,  clear A5A5A5A5
//    1: depth 16, latency 2, WRITE_FIRST, clear A5A5A5A5
//    2: depth 12, latency 1, READ_FIRST,  clear 0
//    3: depth 16, latency 1, READ_FIRST,  no clear sweep

module tb_simple_dual_port_be_ram;

   typedef struct {
      logic [31:0] data;
      logic        care;
      int          due;
   } entry_t;

   localparam int LAT   [4] = '{1, 2, 1, 1};
   localparam int DEPTH [4] = '{16, 16, 12, 0};

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr = 1'b0;
   logic [3:0]  wr_addr = '0;
   logic [3:0]  wr_be = '0;
   logic [31:0] wr_data = '0;
   logic        rd = 1'b0;
   logic [3:0]  rd_addr = '0;

   logic [31:0] rd_data  [4];
   logic        rd_valid [4];
   logic        busy     [4];

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          left [4] = '{16, 16, 12, 0};

   entry_t      sb [4][$];
   logic [31:0] last_d [4] = '{32'h0, 32'h0, 32'h0, 32'h0};
   logic        last_c [4] = '{1'b1, 1'b1, 1'b1, 1'b1};
   logic        exp_v;
   logic        exp_b;
   entry_t      ent;

   always #5 clk = ~clk;

   simple_dual_port_be_ram #(
      .RAM_DEPTH(16), .RD_LATENCY(1), .RDW_MODE("READ_FIRST"),
      .CLEAR_ON_RESET("TRUE"), .CLEAR_VAL(32'hA5A5A5A5)
   ) u_a (
      .clk_i(clk), .rst_i(rst), .wr_i(wr), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
      .wr_data_i(wr_data), .rd_i(rd), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data[0]), .rd_valid_o(rd_valid[0]), .busy_o(busy[0])
   );

   simple_dual_port_be_ram #(
      .RAM_DEPTH(16), .RD_LATENCY(2), .RDW_MODE("WRITE_FIRST"),
      .CLEAR_ON_RESET("TRUE"), .CLEAR_VAL(32'hA5A5A5A5)
   ) u_b (
      .clk_i(clk), .rst_i(rst), .wr_i(wr), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
      .wr_data_i(wr_data), .rd_i(rd), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data[1]), .rd_valid_o(rd_valid[1]), .busy_o(busy[1])
   );

   simple_dual_port_be_ram #(
      .RAM_DEPTH(12), .RD_LATENCY(1), .RDW_MODE("READ_FIRST"),
      .CLEAR_ON_RESET("TRUE"), .CLEAR_VAL(32'h00000000)
   ) u_c (
      .clk_i(clk), .rst_i(rst), .wr_i(wr), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
      .wr_data_i(wr_data), .rd_i(rd), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data[2]), .rd_valid_o(rd_valid[2]), .busy_o(busy[2])
   );

   simple_dual_port_be_ram #(
      .RAM_DEPTH(16), .RD_LATENCY(1), .RDW_MODE("READ_FIRST"),
      .CLEAR_ON_RESET("FALSE")
   ) u_d (
      .clk_i(clk), .rst_i(rst), .wr_i(wr), .wr_addr_i(wr_addr), .wr_be_i(wr_be),
      .wr_data_i(wr_data), .rd_i(rd), .rd_addr_i(rd_addr),
      .rd_data_o(rd_data[3]), .rd_valid_o(rd_valid[3]), .busy_o(busy[3])
   );

   // Remaining sweep edges per instance; reloaded while reset is held.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 4; i++) begin
         if (rst) begin
            left[i] <= DEPTH[i];
         end else if (left[i] != 0) begin
            left[i] <= left[i] - 1;
         end
      end
   end

   // Scoreboard monitor: busy, strobe timing, read data and hold behaviour.
   always @(negedge clk) begin
      for (int i = 0; i < 4; i++) begin
         exp_b = rst ? (DEPTH[i] != 0) : (left[i] != 0);
         checks++;
         if (busy[i] !== exp_b) begin
            errors++;
            $display("FAIL busy inst %0d cyc %0d got %b exp %b", i, cyc, busy[i], exp_b);
         end
         exp_v = (sb[i].size() != 0) && (sb[i][0].due == cyc);
         checks++;
         if (rd_valid[i] !== exp_v) begin
            errors++;
            $display("FAIL rd_valid inst %0d cyc %0d got %b exp %b", i, cyc, rd_valid[i], exp_v);
         end
         if (exp_v) begin
            ent       = sb[i].pop_front();
            last_d[i] = ent.data;
            last_c[i] = ent.care;
         end
         if (last_c[i]) begin
            checks++;
            if (rd_data[i] !== last_d[i]) begin
               errors++;
               $display("FAIL rd_data inst %0d cyc %0d got %h exp %h", i, cyc, rd_data[i], last_d[i]);
            end
         end
      end
   end

   task automatic access(input logic w, input logic [3:0] wa, input logic [3:0] be,
                         input logic [31:0] wd, input logic r, input logic [3:0] ra,
                         input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] ec,
                         input logic [31:0] ed, input logic dcare);
      logic [31:0] ex [4];
      ex      = '{ea, eb, ec, ed};
      wr      = w;
      wr_addr = wa;
      wr_be   = be;
      wr_data = wd;
      rd      = r;
      rd_addr = ra;
      if (r) begin
         for (int i = 0; i < 4; i++) begin
            if (left[i] == 0) begin
               sb[i].push_back(entry_t'{data: ex[i], care: (i == 3) ? dcare : 1'b1, due: cyc + LAT[i]});
            end
         end
      end
      @(posedge clk);
      #1;
      wr = 1'b0;
      rd = 1'b0;
   endtask

   task automatic wr_only(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
      access(1'b1, a, be, d, 1'b0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
   endtask

   task automatic rd_only(input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb,
                          input logic [31:0] ec, input logic [31:0] ed, input logic dcare);
      access(1'b0, 4'd0, 4'd0, 32'h0, 1'b1, a, ea, eb, ec, ed, dcare);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic assert_reset();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sb[i].delete();
         last_d[i] = 32'h0;
         last_c[i] = 1'b1;
      end
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic count_sweep(output int na, output int nc);
      logic ba;
      logic bc;
      na = 0;
      nc = 0;
      for (int k = 0; k < 20; k++) begin
         ba = busy[0];
         bc = busy[2];
         @(posedge clk);
         #1;
         if (ba) na++;
         if (bc) nc++;
      end
   endtask

   task automatic test_reset();
      #1;
      assert_reset();
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_data[i] !== 32'h0 || rd_valid[i] !== 1'b0 || busy[i] !== (i != 3)) begin
            errors++;
            $display("FAIL reset_state inst %0d got data %h valid %b busy %b exp 0 0 %b",
                     i, rd_data[i], rd_valid[i], busy[i], (i != 3));
         end
      end
   endtask

   task automatic test_clear_sweep();
      int na;
      int nc;
      release_reset();
      count_sweep(na, nc);
      checks++;
      if (na !== 16) begin
         errors++;
         $display("FAIL sweep_len16 got %0d exp 16", na);
      end
      checks++;
      if (nc !== 12) begin
         errors++;
         $display("FAIL sweep_len12 got %0d exp 12", nc);
      end
      for (int a = 0; a < 16; a++) begin
         rd_only(4'(a), 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0);
      end
      idle(3);
   endtask

   task automatic test_byte_enables();
      wr_only(4'd3, 4'b1111, 32'h11223344);
      wr_only(4'd3, 4'b0101, 32'hAABBCCDD);
      rd_only(4'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD, 1'b1);
      idle(3);
   endtask

   task automatic test_collision();
      wr_only(4'd5, 4'b1111, 32'h0);
      access(1'b1, 4'd5, 4'b0011, 32'hDEADBEEF, 1'b1, 4'd5,
             32'h00000000, 32'h0000BEEF, 32'h00000000, 32'h00000000, 1'b1);
      rd_only(4'd5, 32'h0000BEEF, 32'h0000BEEF, 32'h0000BEEF, 32'h0000BEEF, 1'b1);
      idle(3);
   endtask

   task automatic test_latency();
      wr_only(4'd0, 4'b1111, 32'd10);
      wr_only(4'd1, 4'b1111, 32'd20);
      wr_only(4'd2, 4'b1111, 32'd30);
      rd_only(4'd0, 32'd10, 32'd10, 32'd10, 32'd10, 1'b1);
      rd_only(4'd1, 32'd20, 32'd20, 32'd20, 32'd20, 1'b1);
      rd_only(4'd2, 32'd30, 32'd30, 32'd30, 32'd30, 1'b1);
      idle(4);
      checks++;
      if (rd_data[1] !== 32'd30 || rd_valid[1] !== 1'b0) begin
         errors++;
         $display("FAIL lat2_hold got %h valid %b exp 0000001e valid 0", rd_data[1], rd_valid[1]);
      end
   endtask

   task automatic test_reset_mid();
      int na;
      int nc;
      // Read in flight in the latency-2 instance when reset hits.
      rd_only(4'd0, 32'd10, 32'd10, 32'd10, 32'd10, 1'b1);
      #5;
      assert_reset();
      #1;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (rd_data[i] !== 32'h0 || rd_valid[i] !== 1'b0 || busy[i] !== (i != 3)) begin
            errors++;
            $display("FAIL async_reset inst %0d got data %h valid %b busy %b exp 0 0 %b",
                     i, rd_data[i], rd_valid[i], busy[i], (i != 3));
         end
      end
      release_reset();
      repeat (7) @(posedge clk);
      #2;
      assert_reset();
      #1;
      checks++;
      if (busy[0] !== 1'b1 || rd_data[0] !== 32'h0) begin
         errors++;
         $display("FAIL midsweep_reset got busy %b data %h exp 1 0", busy[0], rd_data[0]);
      end
      release_reset();
      count_sweep(na, nc);
      checks++;
      if (na !== 16 || nc !== 12) begin
         errors++;
         $display("FAIL sweep_restart got %0d/%0d exp 16/12", na, nc);
      end
      idle(2);
   endtask

   task automatic test_busy_access();
      #2;
      assert_reset();
      release_reset();
      idle(10);
      access(1'b1, 4'd2, 4'b1111, 32'hFFFFFFFF, 1'b1, 4'd2, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      access(1'b1, 4'd1, 4'b1111, 32'hFFFFFFFF, 1'b1, 4'd1, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
      idle(8);
      for (int a = 0; a < 16; a++) begin
         rd_only(4'(a), 32'hA5A5A5A5, 32'hA5A5A5A5, 32'h0, 32'h0, 1'b0);
      end
      idle(3);
   endtask

   task automatic test_range();
      wr_only(4'd13, 4'b1111, 32'hFFFFFFFF);
      rd_only(4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFF, 1'b1);
      wr_only(4'd11, 4'b1111, 32'h12345678);
      rd_only(4'd11, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 1'b1);
      idle(4);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (sb[i].size() !== 0) begin
            errors++;
            $display("FAIL drain inst %0d got %0d pending exp 0", i, sb[i].size());
         end
      end
   endtask

   initial begin
      test_reset();
      test_clear_sweep();
      test_byte_enables();
      test_collision();
      test_latency();
      test_reset_mid();
      test_busy_access();
      test_range();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
